// File: rtl/bus_decode_mux.sv
// Address decoder, chip-select, wait-state generator and read-data mux for the
// 65C02 system bus. Lower-indexed regions win on overlap.
module bus_decode_mux #(
  parameter int                             NUM_SLAVES   = 4,
  parameter int                             ADDR_W       = 16,
  parameter int                             DATA_W       = 8,
  parameter logic [ADDR_W*NUM_SLAVES-1:0]   REGION_BASE  = {16'h8010, 16'hC000, 16'h8000, 16'h0000},
  parameter logic [ADDR_W*NUM_SLAVES-1:0]   REGION_LIMIT = {16'hBFFF, 16'hFFFF, 16'h800F, 16'h7FFF},
  parameter logic [4*NUM_SLAVES-1:0]        REGION_WAIT  = {4'd1, 4'd0, 4'd2, 4'd0},
  parameter logic [DATA_W-1:0]              DEFAULT_DATA = 8'hEA
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [ADDR_W-1:0]            cpu_ab,
  input  logic                         cpu_we,
  input  logic [DATA_W-1:0]            cpu_do,
  output logic [DATA_W-1:0]            cpu_di,
  output logic                         cpu_rdy,
  output logic [NUM_SLAVES-1:0]        slv_en,
  output logic                         slv_we,
  output logic [DATA_W-1:0]            slv_wdata,
  input  logic [DATA_W*NUM_SLAVES-1:0] slv_rdata,
  output logic [ADDR_W-1:0]            ext_ab,
  output logic                         unmapped,
  output logic [7:0]                   unmapped_cnt
);

  localparam int SEL_W = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;

  typedef enum logic {ST_IDLE, ST_WAIT} state_t;

  typedef struct packed {
    logic             vld;
    logic [SEL_W-1:0] idx;
  } rsel_t;

  generate
    if (NUM_SLAVES < 1 || NUM_SLAVES > 8) begin : g_bad_num_slaves
      $error("bus_decode_mux: NUM_SLAVES must be in 1..8");
    end
    for (genvar g = 0; g < NUM_SLAVES; g++) begin : g_region_chk
      if (REGION_BASE[g*ADDR_W +: ADDR_W] > REGION_LIMIT[g*ADDR_W +: ADDR_W]) begin : g_bad_region
        $error("bus_decode_mux: region base above its limit");
      end
    end
  endgenerate

  logic             hit_any;
  logic [SEL_W-1:0] sel;
  logic [3:0]       wait_sel;
  state_t           state, state_n;
  logic [3:0]       cnt, cnt_n;
  rsel_t            rsel;

  // Scanning from the top index down leaves the lowest hitting region in sel.
  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    hit_any = 1'b0;
    sel     = '0;
    for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
      if (cpu_ab >= REGION_BASE[i*ADDR_W +: ADDR_W] &&
          cpu_ab <= REGION_LIMIT[i*ADDR_W +: ADDR_W]) begin
        hit_any = 1'b1;
        sel     = i[SEL_W-1:0];
      end
    end
  end

  assign wait_sel  = hit_any ? REGION_WAIT[sel*4 +: 4] : 4'd0;
  assign slv_en    = hit_any ? (NUM_SLAVES'(1) << sel) : '0;
  assign slv_wdata = cpu_do;
  assign slv_we    = cpu_we && cpu_rdy && hit_any;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
      cnt   <= 4'd0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    case (state)
      ST_IDLE: begin
        if (wait_sel != 4'd0) begin
          state_n = ST_WAIT;
          cnt_n   = wait_sel - 4'd1;
        end
      end
      ST_WAIT: begin
        if (cnt == 4'd0) state_n = ST_IDLE;
        else             cnt_n   = cnt - 4'd1;
      end
      default: state_n = ST_IDLE;
    endcase
  end

  always_comb begin
    cpu_rdy = 1'b1;
    case (state)
      ST_IDLE: cpu_rdy = (wait_sel == 4'd0);
      ST_WAIT: cpu_rdy = (cnt == 4'd0);
      default: cpu_rdy = 1'b1;
    endcase
  end

  // Slaves answer one cycle after the completing edge, so the mux select is
  // captured on that same edge and held through any following stall.
  always_ff @(posedge clk) begin
    if (reset) begin
      rsel         <= '0;
      ext_ab       <= '0;
      unmapped     <= 1'b0;
      unmapped_cnt <= 8'd0;
    end else begin
      unmapped <= cpu_rdy && !hit_any;
      if (cpu_rdy) begin
        rsel.vld <= hit_any && !cpu_we;
        rsel.idx <= sel;
        ext_ab   <= cpu_ab;
        if (!hit_any && unmapped_cnt != 8'hFF) unmapped_cnt <= unmapped_cnt + 8'd1;
      end
    end
  end

  assign cpu_di = rsel.vld ? slv_rdata[rsel.idx*DATA_W +: DATA_W] : DEFAULT_DATA;

endmodule

// File: tb/tb_bus_decode_mux.sv
// Directed bench for bus_decode_mux: default map plus a second instance whose
// region 0 is trimmed to 16'h7FEF to exercise unmapped handling.
module tb_bus_decode_mux;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] cpu_ab;
  logic        cpu_we;
  logic [7:0]  cpu_do;
  logic [31:0] slv_rdata;

  logic [7:0]  cpu_di,   cpu_di_2;
  logic        cpu_rdy,  cpu_rdy_2;
  logic [3:0]  slv_en,   slv_en_2;
  logic        slv_we,   slv_we_2;
  logic [7:0]  slv_wdata, slv_wdata_2;
  logic [15:0] ext_ab,   ext_ab_2;
  logic        unmapped, unmapped_2;
  logic [7:0]  unmapped_cnt, unmapped_cnt_2;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  bus_decode_mux u_dut (
    .clk(clk), .reset(reset), .cpu_ab(cpu_ab), .cpu_we(cpu_we), .cpu_do(cpu_do),
    .cpu_di(cpu_di), .cpu_rdy(cpu_rdy), .slv_en(slv_en), .slv_we(slv_we),
    .slv_wdata(slv_wdata), .slv_rdata(slv_rdata), .ext_ab(ext_ab),
    .unmapped(unmapped), .unmapped_cnt(unmapped_cnt)
  );

  bus_decode_mux #(
    .REGION_LIMIT({16'hBFFF, 16'hFFFF, 16'h800F, 16'h7FEF})
  ) u_dut_trim (
    .clk(clk), .reset(reset), .cpu_ab(cpu_ab), .cpu_we(cpu_we), .cpu_do(cpu_do),
    .cpu_di(cpu_di_2), .cpu_rdy(cpu_rdy_2), .slv_en(slv_en_2), .slv_we(slv_we_2),
    .slv_wdata(slv_wdata_2), .slv_rdata(slv_rdata), .ext_ab(ext_ab_2),
    .unmapped(unmapped_2), .unmapped_cnt(unmapped_cnt_2)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; checks run on the falling edge.
  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  initial begin
    reset     = 1'b1;
    cpu_ab    = 16'h1234;
    cpu_we    = 1'b0;
    cpu_do    = 8'h00;
    slv_rdata = {8'h33, 8'h00, 8'h11, 8'h5A};
    cycle();
    cycle();
    sample();
    check("reset_cpu_di",    cpu_di, 8'hEA);
    check("reset_ext_ab",    ext_ab, 16'h0000);
    check("reset_unmapped",  unmapped, 1'b0);
    check("reset_cnt",       unmapped_cnt, 8'd0);
    check("reset_slv_en",    slv_en, 4'b0001);

    // Zero-wait read from region 0
    cycle(); reset = 1'b0;
    sample();
    check("r0_rdy",    cpu_rdy, 1'b1);
    check("r0_en",     slv_en, 4'b0001);
    check("r0_we",     slv_we, 1'b0);

    // Two-wait write to region 1
    cycle(); cpu_ab = 16'h8000; cpu_we = 1'b1; cpu_do = 8'h41;
    sample();
    check("r0_di",     cpu_di, 8'h5A);
    check("r0_ext_ab", ext_ab, 16'h1234);
    check("w1_c1_rdy", cpu_rdy, 1'b0);
    check("w1_c1_en",  slv_en, 4'b0010);
    check("w1_c1_we",  slv_we, 1'b0);
    cycle();
    sample();
    check("w1_c2_rdy", cpu_rdy, 1'b0);
    check("w1_c2_en",  slv_en, 4'b0010);
    check("w1_c2_we",  slv_we, 1'b0);
    check("w1_c2_ab",  ext_ab, 16'h1234);
    cycle();
    sample();
    check("w1_c3_rdy", cpu_rdy, 1'b1);
    check("w1_c3_en",  slv_en, 4'b0010);
    check("w1_c3_we",  slv_we, 1'b1);
    check("w1_c3_wd",  slv_wdata, 8'h41);

    // One-wait read from region 3
    cycle(); cpu_ab = 16'hA000; cpu_we = 1'b0; slv_rdata = {8'h77, 8'h00, 8'h11, 8'h5A};
    sample();
    check("w1_di",     cpu_di, 8'hEA);
    check("w1_ext_ab", ext_ab, 16'h8000);
    check("r3_c1_rdy", cpu_rdy, 1'b0);
    check("r3_c1_en",  slv_en, 4'b1000);
    cycle();
    sample();
    check("r3_c2_rdy", cpu_rdy, 1'b1);
    check("r3_c2_di",  cpu_di, 8'hEA);
    check("r3_c2_ab",  ext_ab, 16'h8000);

    // Back-to-back zero-wait reads from region 2
    cycle(); cpu_ab = 16'hFFFC;
    sample();
    check("r3_di",     cpu_di, 8'h77);
    check("r3_ext_ab", ext_ab, 16'hA000);
    check("r2a_rdy",   cpu_rdy, 1'b1);
    check("r2a_en",    slv_en, 4'b0100);
    cycle(); cpu_ab = 16'hFFFD; slv_rdata = {8'h77, 8'hC1, 8'h11, 8'h5A};
    sample();
    check("r2a_di",    cpu_di, 8'hC1);
    check("r2b_rdy",   cpu_rdy, 1'b1);
    cycle(); cpu_ab = 16'h0100; slv_rdata = {8'h77, 8'hC2, 8'h11, 8'h5A};
    sample();
    check("r2b_di",    cpu_di, 8'hC2);
    check("r2b_ext_ab", ext_ab, 16'hFFFD);

    // Unmapped read on the trimmed map; still region 0 on the default map
    cycle(); cpu_ab = 16'h7FF5;
    sample();
    check("um_en_trim",   slv_en_2, 4'b0000);
    check("um_en_full",   slv_en, 4'b0001);
    check("um_rdy_trim",  cpu_rdy_2, 1'b1);
    check("um_cnt_pre",   unmapped_cnt_2, 8'd0);
    check("um_pulse_pre", unmapped_2, 1'b0);
    cycle(); cpu_ab = 16'h0100;
    sample();
    check("um_di",        cpu_di_2, 8'hEA);
    check("um_pulse",     unmapped_2, 1'b1);
    check("um_cnt_1",     unmapped_cnt_2, 8'd1);
    check("um_full_none", unmapped, 1'b0);
    cycle();
    sample();
    check("um_pulse_end", unmapped_2, 1'b0);
    check("um_cnt_hold",  unmapped_cnt_2, 8'd1);

    // Saturation: mixed read/write unmapped accesses, no write strobe issued
    for (int i = 0; i < 253; i++) begin
      cycle(); cpu_ab = 16'h7FF5; cpu_we = i[0];
    end
    sample();
    check("um_wr_no_we",  slv_we_2, 1'b0);
    cycle(); cpu_ab = 16'h0100; cpu_we = 1'b0;
    sample();
    check("um_cnt_254",   unmapped_cnt_2, 8'd254);
    for (int i = 0; i < 46; i++) begin
      cycle(); cpu_ab = 16'h7FF5;
    end
    cycle(); cpu_ab = 16'h0100;
    sample();
    check("um_cnt_sat",   unmapped_cnt_2, 8'd255);
    check("um_cnt_full",  unmapped_cnt, 8'd0);

    // Reset in the second stall cycle of a region-1 write
    cycle(); cpu_ab = 16'h8000; cpu_we = 1'b1; cpu_do = 8'h99;
    sample();
    check("rw_c1_rdy", cpu_rdy, 1'b0);
    cycle(); reset = 1'b1;
    sample();
    check("rw_c2_we",  slv_we, 1'b0);
    cycle(); reset = 1'b0;
    sample();
    check("rw_post_rdy",   cpu_rdy, 1'b0);
    check("rw_post_we",    slv_we, 1'b0);
    check("rw_post_di",    cpu_di, 8'hEA);
    check("rw_post_cnt",   unmapped_cnt_2, 8'd0);
    check("rw_post_ab",    ext_ab, 16'h0000);
    cycle();
    sample();
    check("rw_restart_we", slv_we, 1'b0);
    cycle();
    sample();
    check("rw_restart_done", slv_we, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/bus_decode_mux.md
Name: bus_decode_mux

Overview:
Parametrised address decoder, chip-select and read-data mux for the 65C02 system bus. It supports N memory-mapped slave regions, each with a configurable base/limit and a per-region wait-state count. It drives the CPU RDY line to stall the CPU during wait states, and it replaces hard-coded RAM/ROM/ACIA/bus select logic in system tops. Read data is steered through a select register aligned to synchronous (1-cycle) slave read latency; unmapped reads return a default opcode byte.

Parameters:
NUM_SLAVES, 4, number of decoded regions (1..8)
ADDR_W, 16, CPU address width
DATA_W, 8, data width
REGION_BASE, {16'h8010,16'hC000,16'h8000,16'h0000}, packed ADDR_W*NUM_SLAVES; inclusive base; region i in slice i
REGION_LIMIT, {16'hBFFF,16'hFFFF,16'h800F,16'h7FFF}, packed; inclusive limit per region
REGION_WAIT, {4'd1,4'd0,4'd2,4'd0}, packed 4 bits per region; wait states 0..15
DEFAULT_DATA, 8'hEA, byte returned on unmapped read (NOP)

Ports:
clk  in  1  system clock (phi2 domain)
reset  in  1  synchronous, active-high
cpu_ab  in  ADDR_W  CPU address bus
cpu_we  in  1  CPU write enable
cpu_do  in  DATA_W  CPU write data
cpu_di  out  DATA_W  read data to CPU
cpu_rdy  out  1  CPU ready; low stalls CPU (CPU holds cpu_ab/cpu_we/cpu_do)
slv_en  out  NUM_SLAVES  one-hot slave enable
slv_we  out  1  write strobe to the enabled slave
slv_wdata  out  DATA_W  write data (= cpu_do)
slv_rdata  in  DATA_W*NUM_SLAVES  slave read data, slice i from slave i, valid 1 cycle after enabled read
ext_ab  out  ADDR_W  registered address to external pads
unmapped  out  1  1-cycle pulse on completed access to unmapped address
unmapped_cnt  out  8  saturating count of unmapped accesses

Behaviour:
- Decode is combinational: hit[i] = (cpu_ab >= BASE[i]) && (cpu_ab <= LIMIT[i]). sel is the lowest index with hit set (overlap priority: lower index wins). slv_en = onehot(sel), or 0 when there is no hit.
- slv_en stays asserted through every cycle of a stalled access.
- Wait FSM, states IDLE and WAIT, with 4-bit counter cnt:
  - IDLE, W = REGION_WAIT[sel] (0 if unmapped): W==0 -> cpu_rdy=1, stay IDLE. W>0 -> cpu_rdy=0, go WAIT, cnt <= W-1.
  - WAIT: cnt==0 -> cpu_rdy=1, go IDLE. Else cpu_rdy=0, cnt <= cnt-1.
  - Access therefore occupies W+1 cycles. cpu_rdy is combinational from the state, cnt and decode.
- Back-to-back accesses: each access returning to IDLE re-evaluates the new address. Consecutive zero-wait accesses run at 1/cycle.
- slv_we = cpu_we && cpu_rdy && (hit to some region): a single strobe in the final cycle of the access only.
- Read mux: select register rsel (index plus a valid bit) captures {sel, hit && !cpu_we} on clk edges where cpu_rdy=1, and holds otherwise.
  - cpu_di = rsel.valid ? slv_rdata[rsel] : DEFAULT_DATA.
  - A write cycle or unmapped cycle leaves rsel.valid=0, so cpu_di shows DEFAULT_DATA.
- ext_ab <= cpu_ab on edges where cpu_rdy=1.
- unmapped pulses in the cycle after a completed (cpu_rdy=1) access with no hit, read or write. unmapped_cnt increments on the same event and saturates at 255.
- Reset (synchronous): state=IDLE, cnt=0, rsel.valid=0 (cpu_di=DEFAULT_DATA), ext_ab=0, unmapped=0, unmapped_cnt=0.
  - Outputs combinational from decode (slv_en, cpu_rdy) follow cpu_ab immediately after reset.
  - Reset mid-WAIT aborts the stall; no slv_we is issued for the aborted access.
- Parameter sanity: elaboration fails ($error) if NUM_SLAVES is outside 1..8 or BASE[i] > LIMIT[i].

Test Plan:
- Read 16'h1234 (region 0, W=0), slave0 rdata=8'h5A: slv_en=4'b0001, cpu_rdy=1 throughout; cpu_di=8'h5A next cycle; ext_ab=16'h1234.
- Write 8'h41 to 16'h8000 (region 1, W=2): cpu_rdy low 2 cycles then high; slv_en=4'b0010 for 3 cycles; slv_we high only in 3rd cycle with slv_wdata=8'h41.
- Read 16'hA000 (region 3, W=1), rdata3=8'h77: cpu_rdy 0 then 1; rsel updates only on rdy cycle; cpu_di=8'h77 the cycle after; ext_ab unchanged during stall.
- Read 16'hFFFC then 16'hFFFD (region 2, back-to-back): no stall; cpu_di tracks rdata2 each following cycle.
- Rebuild with region 0 limit 16'h7FEF and read 16'h7FF5: slv_en=0, cpu_di=8'hEA, unmapped pulse, unmapped_cnt 0->1. After 300 unmapped accesses, unmapped_cnt=255.
- Assert reset during second wait cycle of region 1 write: cpu_rdy per new decode next cycle, no slv_we pulse, cpu_di=8'hEA, unmapped_cnt=0.
